// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences operand-buffer reads for one systolic tile.
// Feeds k_len operand columns (rd_en / a_addr / b_addr, with feed_valid one
// cycle later), then DRAIN zero-feed cycles to flush skew and array pipeline,
// then a one-cycle done pulse. stall freezes sequencing in READ and DRAIN.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, k_len          tile request and column count (sampled in IDLE)
//   base_a, base_b        first A/B buffer addresses (sampled with start)
//   stall                 downstream hold
//   rd_en                 buffer read strobe (combinational: READ & !stall)
//   a_addr, b_addr        read addresses, held outside READ
//   feed_valid, zero_feed skew-buffer input qualifiers
//   acc_clear, busy, done accumulator clear pulse, activity, completion pulse
module systolic_feed_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned K_W    = 9,
  parameter int unsigned DRAIN  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              feed_valid,
  output logic              zero_feed,
  output logic              acc_clear,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int unsigned CNT_W   = (K_W > DRAIN_W) ? K_W : DRAIN_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [K_W-1:0]    k_len_q, k_len_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic              feed_valid_q, feed_valid_d;
  logic              zero_feed_q, zero_feed_d;
  logic              acc_clear_q, acc_clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_c;
  logic [CNT_W-1:0]  last_col_c;

  // Index of the final operand column of the latched tile.
  assign last_col_c = CNT_W'(k_len_q) - CNT_W'(1);

  // Next-state, counter, address and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_len_d     = k_len_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    acc_clear_d = 1'b0;
    rd_en_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_len_d     = k_len;
            base_a_d    = base_a;
            base_b_d    = base_b;
            cnt_d       = '0;
            acc_clear_d = 1'b1;
            state_d     = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        rd_en_c = !stall;
        if (!stall) begin
          if (cnt_q == last_col_c) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (cnt_q == CNT_W'(DRAIN - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Addresses track base+cnt only while reading; otherwise they hold.
    if (state_d == S_READ) begin
      a_addr_d = base_a_d + ADDR_W'(cnt_d);
      b_addr_d = base_b_d + ADDR_W'(cnt_d);
    end

    feed_valid_d = rd_en_c;
    zero_feed_d  = (state_d == S_DRAIN);
    busy_d       = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      k_len_q      <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      feed_valid_q <= 1'b0;
      zero_feed_q  <= 1'b0;
      acc_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_len_q      <= k_len_d;
      base_a_q     <= base_a_d;
      base_b_q     <= base_b_d;
      a_addr_q     <= a_addr_d;
      b_addr_q     <= b_addr_d;
      feed_valid_q <= feed_valid_d;
      zero_feed_q  <= zero_feed_d;
      acc_clear_q  <= acc_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_c;
  assign a_addr     = a_addr_q;
  assign b_addr     = b_addr_q;
  assign feed_valid = feed_valid_q;
  assign zero_feed  = zero_feed_q;
  assign acc_clear  = acc_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the operand buffer address width.
REQ-002 SHALL have parameter K_W, default 9, meaning the width of the accumulation-length field.
REQ-003 SHALL have parameter DRAIN, default 7, meaning the number of zero-feed cycles after the last operand column (skew plus array pipeline).
REQ-004 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: start  input  1  request to run one tile; sampled only in IDLE.
REQ-007 SHALL have port: k_len  input  K_W  number of operand columns to feed; sampled with start.
REQ-008 SHALL have port: base_a / base_b  input  ADDR_W each  first A-buffer / B-buffer address; sampled with start.
REQ-009 SHALL have port: stall  input  1  downstream hold; freezes sequencing while high.
REQ-010 SHALL have port: rd_en  output  1  operand buffer read strobe, 1-cycle read latency assumed downstream.
REQ-011 SHALL have port: a_addr / b_addr  output  ADDR_W each  current read addresses.
REQ-012 SHALL have port: feed_valid  output  1  operand data at skew-buffer input is valid this cycle.
REQ-013 SHALL have port: zero_feed  output  1  skew-buffer input shall be forced to 0 this cycle.
REQ-014 SHALL have port: acc_clear  output  1  one-cycle pulse clearing the array accumulators.
REQ-015 SHALL have port: busy  output  1  high in READ and DRAIN.
REQ-016 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE with an internal counter cnt (width max(K_W, clog2(DRAIN))).
REQ-018 IDLE: start=1 and k_len!=0 SHALL latch k_len/base_a/base_b, clear cnt, pulse acc_clear the following cycle, go to READ.
REQ-019 IDLE: start=1 and k_len==0 SHALL go directly to DONE with no rd_en and no acc_clear.
REQ-020 READ: rd_en SHALL equal !stall (combinational); a_addr=base_a+cnt, b_addr=base_b+cnt, modulo 2^ADDR_W (wrap, no error).
REQ-021 READ: cnt SHALL increment only on cycles with rd_en=1; rd_en with cnt==k_len-1 SHALL transition to DRAIN and clear cnt.
REQ-022 feed_valid SHALL be rd_en registered by one cycle, independent of later stall.
REQ-023 DRAIN: zero_feed SHALL be 1 in every DRAIN cycle; cnt SHALL increment when stall=0; stall=0 with cnt==DRAIN-1 SHALL go to DONE.
REQ-024 DONE: done SHALL be 1 for exactly that cycle; next state IDLE unconditionally.
REQ-025 start outside IDLE (READ, DRAIN, DONE) SHALL be ignored and SHALL NOT alter latched parameters.
REQ-026 a_addr/b_addr SHALL hold their last value outside READ; rd_en SHALL be 0 outside READ.
REQ-027 Timing, start accepted at cycle T, no stall, k_len=K: READ T+1..T+K, feed_valid T+2..T+K+1, DRAIN T+K+1..T+K+DRAIN, done at T+K+DRAIN+1.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, latched registers 0, and all outputs 0 (rd_en, feed_valid, zero_feed, acc_clear, busy, done, a_addr, b_addr).
REQ-029 Reset asserted mid-READ or mid-DRAIN SHALL abort the tile with no done pulse; first start after release SHALL be honoured normally.

Verification
REQ-030 k_len=4, base_a=0x0010, base_b=0x0200, start at T -> acc_clear at T+1, rd_en T+1..T+4 with a_addr 0x10..0x13, b_addr 0x200..0x203, feed_valid T+2..T+5, zero_feed T+5..T+11, done at T+12 only.
REQ-031 k_len=4, stall high for 2 cycles at T+2 -> rd_en low those cycles, a_addr holds 0x11, done at T+14, exactly 4 rd_en pulses.
REQ-032 k_len=0 start -> done one cycle later, no rd_en, no acc_clear, busy stays 0.
REQ-033 base_a=0xFFFE, k_len=4 -> a_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-034 start pulsed again during READ and DONE -> ignored; single done per accepted start.
REQ-035 rst_n low at T+3 of REQ-030 run -> all outputs 0 immediately, no done; new start after release runs the full sequence.
